// File: rtl/store_rmw_pkg.sv
// store_rmw_pkg: funct3 encodings, FSM states and request classification shared by the store RMW unit.
package store_rmw_pkg;
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;
  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, ERR} state_e;
  function automatic logic f3_legal(input logic [2:0] f3, input int xlen);
    return !f3[2] && (f3 != F3_SD || xlen == 64);
  endfunction
  function automatic logic f3_full(input logic [2:0] f3, input int xlen);
    return xlen == 64 ? f3 == F3_SD : f3 == F3_SW;
  endfunction
  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] a);
    return f3 == F3_SH ? a[0] : f3 == F3_SW ? |a[1:0] : f3 == F3_SD ? |a : 1'b0;
  endfunction
endpackage

// File: rtl/store_merge.sv
// store_merge: little-endian lane merge of store data into a read word; sub-size offset bits are dropped.
module store_merge
  import store_rmw_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]             rdata_i,
  input  logic [XLEN-1:0]             wdata_i,
  input  logic [$clog2(XLEN/8)-1:0]   offset_i,
  input  logic [2:0]                  funct3_i,
  output logic [XLEN-1:0]             merged_o
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  logic [2:0]      size_m1;
  logic [7:0]      bmask;
  logic [OW-1:0]   off;
  logic [NB-1:0]   lanes;
  logic [XLEN-1:0] sdata;
  assign size_m1 = funct3_i == F3_SB ? 3'd0 : funct3_i == F3_SH ? 3'd1 : funct3_i == F3_SW ? 3'd3 : 3'd7;
  assign bmask   = funct3_i == F3_SB ? 8'h01 : funct3_i == F3_SH ? 8'h03 : funct3_i == F3_SW ? 8'h0F : 8'hFF;
  assign off     = offset_i & ~OW'(size_m1);
  assign lanes   = NB'(bmask) << off;
  assign sdata   = wdata_i << {off, 3'b000};
  for (genvar k = 0; k < NB; k++) begin : g_lane
    assign merged_o[8*k+:8] = lanes[k] ? sdata[8*k+:8] : rdata_i[8*k+:8];
  end
endmodule

// File: rtl/store_rmw_unit.sv
// store_rmw_unit: store sequencer doing read-modify-write for sub-word stores; STORE_RMW_MISALIGN_TRAP_EN traps misaligned stores.
module store_rmw_unit
  import store_rmw_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_data,
  input  logic [2:0]        req_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              mem_wr_en,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              done,
  output logic              err
);
  localparam int OW = $clog2(XLEN / 8);
  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   data_q, wdata_q, merged;
  logic [OW-1:0]     off_q;
  logic [2:0]        f3_q;
  logic              rd_q, wr_q, done_q, err_q, bad;
`ifdef STORE_RMW_MISALIGN_TRAP_EN
  assign bad = !f3_legal(req_funct3, XLEN) || misaligned(req_funct3, req_addr[2:0]);
`else
  assign bad = !f3_legal(req_funct3, XLEN);
`endif
  store_merge #(.XLEN(XLEN)) u_merge (
    .rdata_i  (mem_rdata),
    .wdata_i  (data_q),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .merged_o (merged)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          if (bad) begin
            state_q <= ERR;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            addr_q <= {req_addr[ADDR_W-1:OW], OW'(0)};
            data_q <= req_data;
            off_q  <= req_addr[OW-1:0];
            f3_q   <= req_funct3;
            if (f3_full(req_funct3, XLEN)) begin
              state_q <= WR;
              wr_q    <= 1'b1;
              done_q  <= 1'b1;
              wdata_q <= req_data;
            end else begin
              state_q <= RD;
              rd_q    <= 1'b1;
            end
          end
        end
        RD: state_q <= MERGE;
        // mem_rdata for the RD strobe is valid now
        MERGE: begin
          state_q <= WR;
          wr_q    <= 1'b1;
          done_q  <= 1'b1;
          wdata_q <= merged;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready = state_q == IDLE;
  assign mem_addr  = addr_q;
  assign mem_rd_en = rd_q;
  assign mem_wr_en = wr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule
